// File: rtl/core_pkg.sv
// Shared definitions for the core's fetch stage: PC width, PC type and reset value.
package core_pkg;

    localparam int PC_WIDTH = 5;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET = '0;

endpackage : core_pkg

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the current word address, advances by
// STEP every clock, or takes the ALU branch/jump target when load is set.
// pc_plus4 is the combinational next-sequential address (+STEP, not +4).
module program_counter
    import core_pkg::*;
#(
    parameter int                 WIDTH     = PC_WIDTH,
    parameter int                 STEP      = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(PC_RESET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;

    // Sequential address wraps silently modulo 2^WIDTH.
    assign pc_plus4 = pc + WIDTH'(STEP);

    // Next-pc select: branch/jump target on load, otherwise the sequential address.
    always_comb begin
        pc_next = pc_plus4;
        if (load) begin
            pc_next = alu_out;
        end
    end

    // PC register; reset forces RESET_VAL immediately, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VAL;
        end else begin
            pc <= pc_next;
        end
    end

    assign pc_out = pc;

    // An edge outside reset without load must advance the PC by exactly STEP.
    property p_sequential_advance;
        @(posedge clk) disable iff (!rst)
            (!load) |=> (pc_out == WIDTH'($past(pc_out) + WIDTH'(STEP)));
    endproperty

    a_sequential_advance : assert property (p_sequential_advance);

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, increment, load, wrap,
// asynchronous mid-run reset and back-to-back loads.
module tb_program_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [4:0] alu_out;
    logic [4:0] pc_out;
    logic [4:0] pc_plus4;

    int n_checks;
    int n_fail;

    program_counter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .alu_out  (alu_out),
        .pc_out   (pc_out),
        .pc_plus4 (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Check pc_out and pc_plus4 together, and that they differ by one.
    task automatic check_pc(input string tag, input logic [4:0] exp_pc);
        logic [4:0] exp_plus;
        logic [4:0] back;
        exp_plus = exp_pc + 5'd1;
        back     = pc_plus4 - 5'd1;
        check({tag, "_pc_out"}, pc_out, exp_pc);
        check({tag, "_pc_plus4"}, pc_plus4, exp_plus);
        check({tag, "_plus4_minus1"}, back, pc_out);
        $display("step %s: pc_out=%0d pc_plus4=%0d", tag, pc_out, pc_plus4);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        load     = 1'b0;
        alu_out  = 5'd0;

        // Reset held for one cycle.
        #1;
        check_pc("reset_async", 5'd0);
        tick();
        check_pc("reset_held", 5'd0);
        rst = 1'b1;
        #1;
        check_pc("reset_released", 5'd0);

        // Sequential increment.
        tick();
        check_pc("inc1", 5'd1);
        tick();
        check_pc("inc2", 5'd2);
        tick();
        check_pc("inc3", 5'd3);

        // Single load then resume.
        alu_out = 5'd10;
        load    = 1'b1;
        tick();
        check_pc("load10", 5'd10);
        load = 1'b0;
        tick();
        check_pc("after_load", 5'd11);

        // Wrap-around at the top of the address space.
        alu_out = 5'd31;
        load    = 1'b1;
        tick();
        check_pc("wrap_top", 5'd31);
        load = 1'b0;
        tick();
        check_pc("wrap_zero", 5'd0);

        // Asynchronous reset mid-run while a load is pending.
        alu_out = 5'd7;
        load    = 1'b1;
        tick();
        check_pc("pre_reset7", 5'd7);
        alu_out = 5'd20;
        load    = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_pc("midrun_reset_async", 5'd0);
        tick();
        check_pc("midrun_reset_held", 5'd0);
        rst = 1'b1;
        #1;
        check_pc("midrun_released", 5'd0);
        tick();
        check_pc("first_edge_load20", 5'd20);

        // Back-to-back loads.
        alu_out = 5'd4;
        tick();
        check_pc("b2b_4", 5'd4);
        alu_out = 5'd9;
        tick();
        check_pc("b2b_9", 5'd9);
        alu_out = 5'd2;
        tick();
        check_pc("b2b_2", 5'd2);
        load = 1'b0;
        tick();
        check_pc("b2b_release", 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_program_counter

// File: doc/program_counter.md
# program_counter

Instruction program counter for the single-issue core's fetch stage. Holds the current fetch address in a register and advances it by one word per clock. On request, it loads a branch or jump target computed by the ALU. It presents the current address and a combinational next-sequential address to the instruction memory and the writeback mux.

## Interface
- WIDTH, 5, address width in bits for all address ports.
- STEP, 1, sequential increment added each cycle; addresses are word-indexed.
- RESET_VAL, 0, value forced into the PC while reset is active.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous and active-low. The PC is forced to RESET_VAL immediately while rst=0.
- load  input  1  when 1 at a rising edge, the PC takes alu_out instead of incrementing.
- alu_out  input  WIDTH  branch/jump target from the ALU.
- pc_out  output  WIDTH  current PC, registered.
- pc_plus4  output  WIDTH  pc_out + STEP, combinational.
  - The name is historical; the value is +STEP, not +4.

## Operation
- The block has one register, pc. pc_out is driven directly from pc.
- Next-state select, evaluated at each rising clk with rst=1:
  - load=1: pc <= alu_out.
  - load=0: pc <= pc + STEP, which equals pc_plus4.
- pc_plus4 = pc + STEP, computed modulo 2^WIDTH.
  - Wrap-around is silent: with default parameters, 31 -> 0.
  - No overflow flag.
- alu_out is used only when load=1. It may be any value, including the current pc or pc+STEP.
- load=1 together with alu_out equal to pc+STEP gives the same result as incrementing; no special handling.
- No enable or stall input. The PC changes on every clock edge outside reset.

## Timing
- Reset:
  - Assertion (rst falling to 0) sets pc to RESET_VAL asynchronously, without waiting for clk.
  - pc_out = RESET_VAL and pc_plus4 = RESET_VAL + STEP throughout reset.
  - After rst rises to 1, the first rising edge advances pc (or loads it, if load=1).
  - Reset asserted in the middle of operation overrides load and increment at once.
- Load latency is one cycle.
  - load and alu_out are sampled at edge N; pc_out shows alu_out after edge N.
  - Sequential increments resume from the loaded value at edge N+1.
- Inputs must be stable around the rising edge. Testbenches drive them after an edge and sample pc_out just before the next edge.
- pc_plus4 follows pc_out combinationally within the same cycle. It is not registered.

## Structure
- Shared package (core_pkg) provides:
  - PC_WIDTH = 5.
  - typedef logic [PC_WIDTH-1:0] pc_t.
  - PC_RESET = '0.
- WIDTH and RESET_VAL default to these package values.
- Implementation is a single module:
  - one always_ff with async active-low reset for pc;
  - one continuous assign for pc_plus4;
  - one 2:1 next-pc mux.
- No sub-module.
- Optional SVA: after any edge with rst=1 and load=0, pc_out == $past(pc_out) + STEP.

## Test plan
- Reset: hold rst=0 for 1 cycle, then release.
  - pc_out=0 and pc_plus4=1 during reset.
  - pc_out=0 is still read before the first post-release edge.
- Increment: load=0 for 3 edges after reset.
  - pc_out goes 1, 2, 3.
  - pc_out == pc_plus4 - 1 checked every cycle.
- Load: alu_out=10, load=1 for one edge, then load=0.
  - pc_out=10 after the load edge.
  - pc_out=11 after the next edge.
- Wrap: load alu_out=31, then increment.
  - pc_out=31 with pc_plus4=0.
  - pc_out=0 after the next edge.
- Async reset mid-run: drop rst to 0 between edges while pc=7 and load=1 with alu_out=20.
  - pc_out becomes 0 immediately, before any clk edge.
  - It stays 0 until rst=1 and the next edge.
- Back-to-back loads: load=1 on 3 consecutive edges with alu_out=4, 9, 2.
  - pc_out goes 4, 9, 2.
  - pc_out=3 after load drops.
